// File: rtl/pipe_step_ctrl_if.sv
// Control/status bundle between the board-facing debug logic and the pipeline step sequencer.
interface pipe_step_ctrl_if #(
  parameter int BURST_W = 8
);
  logic               btn_run;
  logic               btn_step;
  logic               btn_halt;
  logic [BURST_W-1:0] burst_len;
  logic               bp_en;
  logic [31:0]        bp_pc;
  logic [31:0]        if_pc;
  logic               step;
  logic [1:0]         state;
  logic               bp_hit;
  logic [31:0]        adv_cnt;

  modport master (
    output btn_run, btn_step, btn_halt, burst_len, bp_en, bp_pc, if_pc,
    input  step, state, bp_hit, adv_cnt
  );

  modport slave (
    input  btn_run, btn_step, btn_halt, burst_len, bp_en, bp_pc, if_pc,
    output step, state, bp_hit, adv_cnt
  );
endinterface

// File: rtl/pipe_step_ctrl.sv
// Run/step/breakpoint sequencer: debounced buttons drive the global pipeline advance enable.
//   state   | meaning
//   S_HALT  | pipeline frozen, waiting for run or step press
//   S_RUN   | free run until halt press or breakpoint
//   S_BURST | advance a fixed number of cycles, then halt
//   S_BPHIT | frozen on breakpointed fetch PC
module pipe_step_ctrl #(
  parameter int DEB_CYC = 4,
  parameter int BURST_W = 8
) (
  input logic            clk,
  input logic            rst,
  pipe_step_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2,
    S_BPHIT = 2'd3
  } state_t;

  logic [2:0]         w_raw;
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [CW-1:0]      r_deb_cnt [3];
  logic [2:0]         w_pulse;
  logic               w_run_p;
  logic               w_step_p;
  logic               w_halt_p;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BURST_W-1:0] r_remaining;
  logic [BURST_W-1:0] w_remaining_nxt;
  logic [BURST_W-1:0] w_burst_load;
  logic               r_skip;
  logic               w_skip_nxt;
  logic               r_bp_hit;
  logic [31:0]        r_adv_cnt;
  logic               w_pc_eq;
  logic               w_bp_match;
  logic               w_step;

  assign w_raw = {bus.btn_halt, bus.btn_step, bus.btn_run};

  // Counter saturates at DEB_CYC so a held button pulses only once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (!r_sync2[i])
          r_deb_cnt[i] <= '0;
        else if (r_deb_cnt[i] != CW'(DEB_CYC))
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      w_pulse[i] = r_sync2[i] & (r_deb_cnt[i] == CW'(DEB_CYC - 1));
  end

  assign w_run_p  = w_pulse[0];
  assign w_step_p = w_pulse[1];
  assign w_halt_p = w_pulse[2];

  assign w_pc_eq      = (bus.if_pc == bus.bp_pc);
  assign w_bp_match   = bus.bp_en & w_pc_eq & ~r_skip;
  assign w_step       = ((r_state == S_RUN) | (r_state == S_BURST)) & ~w_bp_match & ~w_halt_p;
  assign w_burst_load = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_skip_nxt      = r_skip & w_pc_eq;
    case (r_state)
      S_HALT: begin
        if (w_run_p) begin
          w_state_nxt = S_RUN;
        end else if (w_step_p) begin
          w_state_nxt     = S_BURST;
          w_remaining_nxt = w_burst_load;
        end
      end
      S_RUN: begin
        if (w_halt_p)        w_state_nxt = S_HALT;
        else if (w_bp_match) w_state_nxt = S_BPHIT;
      end
      S_BURST: begin
        if (w_halt_p) begin
          w_state_nxt = S_HALT;
        end else if (w_bp_match) begin
          w_state_nxt = S_BPHIT;
        end else begin
          w_remaining_nxt = r_remaining - 1'b1;
          if (r_remaining == BURST_W'(1)) w_state_nxt = S_HALT;
        end
      end
      S_BPHIT: begin
        if (w_halt_p) begin
          w_state_nxt = S_HALT;
        end else if (w_run_p) begin
          w_state_nxt = S_RUN;
          w_skip_nxt  = 1'b1;
        end else if (w_step_p) begin
          w_state_nxt     = S_BURST;
          w_remaining_nxt = w_burst_load;
          w_skip_nxt      = 1'b1;
        end
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HALT;
      r_remaining <= '0;
      r_skip      <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_adv_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_skip      <= w_skip_nxt;
      r_bp_hit    <= (w_state_nxt == S_BPHIT);
      if (w_step) r_adv_cnt <= r_adv_cnt + 32'd1;
    end
  end

  assign bus.step    = w_step;
  assign bus.state   = r_state;
  assign bus.bp_hit  = r_bp_hit;
  assign bus.adv_cnt = r_adv_cnt;
endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Scoreboard bench for pipe_step_ctrl: a cycle-level reference model queues expectations, a negedge monitor checks them.
module tb_pipe_step_ctrl;
  localparam int DEB_CYC = 4;
  localparam int BURST_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_step_ctrl_if #(.BURST_W(BURST_W)) ifc ();

  pipe_step_ctrl #(.DEB_CYC(DEB_CYC), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic        step;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0=HALT 1=RUN 2=BURST 3=BPHIT, history bit0 = newest sampled raw button level.
  int          m_mode;
  int          m_left;
  bit          m_skip;
  bit          m_step;
  logic [31:0] m_cnt;
  logic [15:0] m_hist [3];
  logic [31:0] pc_wrap;
  int          hold [3];

  function automatic bit m_pulse(int b);
    bit p;
    p = !m_hist[b][DEB_CYC+1];
    for (int i = 1; i <= DEB_CYC; i++) p = p & m_hist[b][i];
    return p;
  endfunction

  task automatic tick();
    bit pr, ps, ph, bpm, leave_bp, rst_c;
    exp_t e;
    logic [2:0] raw;
    logic [31:0] pc_c, bppc_c;
    int bl;
    pr  = m_pulse(0);
    ps  = m_pulse(1);
    ph  = m_pulse(2);
    bpm = ifc.bp_en && (ifc.if_pc == ifc.bp_pc) && !m_skip;
    m_step   = (m_mode == 1 || m_mode == 2) && !bpm && !ph;
    e.step   = m_step;
    e.state  = m_mode[1:0];
    e.bp_hit = (m_mode == 3);
    e.cnt    = m_cnt;
    sb.push_back(e);
    raw    = {ifc.btn_halt, ifc.btn_step, ifc.btn_run};
    rst_c  = rst;
    pc_c   = ifc.if_pc;
    bppc_c = ifc.bp_pc;
    bl     = int'(ifc.burst_len);
    if (bl == 0) bl = 1;
    @(posedge clk);
    leave_bp = 1'b0;
    if (rst_c) begin
      m_mode = 0; m_left = 0; m_skip = 1'b0; m_cnt = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
    end else begin
      if (m_step) m_cnt = m_cnt + 32'd1;
      case (m_mode)
        0: if (pr) m_mode = 1; else if (ps) begin m_mode = 2; m_left = bl; end
        1: if (ph) m_mode = 0; else if (bpm) m_mode = 3;
        2: if (ph) m_mode = 0; else if (bpm) m_mode = 3;
           else begin m_left = m_left - 1; if (m_left == 0) m_mode = 0; end
        default: if (ph) m_mode = 0;
                 else if (pr) begin m_mode = 1; leave_bp = 1'b1; end
                 else if (ps) begin m_mode = 2; m_left = bl; leave_bp = 1'b1; end
      endcase
      if (leave_bp) m_skip = 1'b1;
      else if (pc_c != bppc_c) m_skip = 1'b0;
      for (int b = 0; b < 3; b++) m_hist[b] = {m_hist[b][14:0], raw[b]};
    end
    #1;
    // Pipeline fetch stage model: PC advances only on a step cycle.
    if (m_step && !rst_c)
      ifc.if_pc = (pc_wrap != 0 && ifc.if_pc + 32'd4 == pc_wrap) ? 32'd0 : ifc.if_pc + 32'd4;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0:       ifc.btn_run  = v;
      1:       ifc.btn_step = v;
      default: ifc.btn_halt = v;
    endcase
  endtask

  task automatic press(int b, int len);
    set_btn(b, 1'b1);
    idle(len);
    set_btn(b, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks = checks + 4;
      if (ifc.step !== mon_e.step) begin
        failures++;
        $display("FAIL step t=%0t got=%b exp=%b", $time, ifc.step, mon_e.step);
      end
      if (ifc.state !== mon_e.state) begin
        failures++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, ifc.state, mon_e.state);
      end
      if (ifc.bp_hit !== mon_e.bp_hit) begin
        failures++;
        $display("FAIL bp_hit t=%0t got=%b exp=%b", $time, ifc.bp_hit, mon_e.bp_hit);
      end
      if (ifc.adv_cnt !== mon_e.cnt) begin
        failures++;
        $display("FAIL adv_cnt t=%0t got=%h exp=%h", $time, ifc.adv_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifc.btn_run = 1'b0; ifc.btn_step = 1'b0; ifc.btn_halt = 1'b0;
    ifc.burst_len = '0; ifc.bp_en = 1'b0; ifc.bp_pc = 32'h10; ifc.if_pc = '0;
    pc_wrap = '0;
    m_mode = 0; m_left = 0; m_skip = 1'b0; m_step = 1'b0; m_cnt = '0;
    for (int b = 0; b < 3; b++) begin m_hist[b] = '0; hold[b] = 0; end
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;

    // Short glitch, then a held run press, then halt.
    press(0, 3);
    idle(6);
    press(0, 10);
    idle(4);
    press(2, 6);
    idle(4);

    // Bursts of 3 and of 0 (treated as 1).
    ifc.burst_len = 8'd3;
    press(1, 6);
    idle(8);
    ifc.burst_len = 8'd0;
    press(1, 6);
    idle(8);

    // Breakpoint at 0x10 while running from 0.
    ifc.if_pc = 32'h0; ifc.bp_en = 1'b1; ifc.bp_pc = 32'h10;
    press(0, 6);
    idle(12);
    // Step off the breakpoint, then loop back onto it.
    ifc.burst_len = 8'd1;
    press(1, 6);
    idle(6);
    pc_wrap = 32'h20;
    press(0, 6);
    idle(16);
    ifc.bp_pc = 32'h44;
    idle(3);
    press(2, 6);
    idle(4);
    ifc.bp_en = 1'b0; pc_wrap = '0;

    // Long burst interrupted by halt, then by reset.
    ifc.burst_len = 8'd200;
    press(1, 6);
    idle(10);
    press(2, 6);
    idle(4);
    press(1, 6);
    idle(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(4);

    // Counter wrap: preload near the top while halted.
    force dut.r_adv_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.r_adv_cnt;
    idle(2);
    press(0, 6);
    idle(3);
    press(2, 6);
    idle(4);

    // Randomised phase.
    pc_wrap = 32'h30;
    ifc.if_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] > 0) begin
          set_btn(b, 1'b1);
          hold[b]--;
        end else begin
          set_btn(b, 1'b0);
          if ($urandom_range(0, 24) == 0) hold[b] = int'($urandom_range(1, 9));
        end
      end
      if ($urandom_range(0, 15) == 0) ifc.burst_len = BURST_W'($urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) ifc.bp_en = ~ifc.bp_en;
      if ($urandom_range(0, 60) == 0) ifc.bp_pc = 32'($urandom_range(1, 10)) * 32'd4;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_step_ctrl.md
Name: pipe_step_ctrl

Overview:
Run/step/breakpoint sequencer for the 5-stage pipeline. It produces the single global `step` advance-enable consumed by every stage register and the register-file write. It debounces the board run/step/halt buttons and freezes the pipeline on a fetch-PC breakpoint. It also keeps an advance counter, which is read out on the chip debug outputs.

Parameters:
DEB_CYC, 4, number of consecutive cycles a synchronised button must stay high before it counts as a press (≥1)
BURST_W, 8, width of the burst-length configuration and of the remaining-count register

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
btn_run  input  1  asynchronous raw button; a press requests free run
btn_step  input  1  asynchronous raw button; a press requests a burst
btn_halt  input  1  asynchronous raw button; a press requests a stop
burst_len  input  BURST_W  number of advance cycles per step press; 0 is treated as 1
bp_en  input  1  breakpoint enable
bp_pc  input  32  breakpoint address
if_pc  input  32  current IF-stage PC
step  output  1  pipeline advance enable
state  output  2  0=HALT, 1=RUN, 2=BURST, 3=BPHIT
bp_hit  output  1  high while in BPHIT
adv_cnt  output  32  count of cycles with step=1; wraps modulo 2^32

Behaviour:
- Reset (rst high at a clk edge):
  - state=HALT, step=0, bp_hit=0, adv_cnt=0.
  - Remaining count, skip flag and debouncers cleared.
  - Reset dominates every other input in the same cycle, including mid-burst and in BPHIT.
- Button conditioning, per button:
  - 2-flop synchroniser, then a saturating counter that counts consecutive cycles of synchronised high.
  - Counter clears to 0 on any synchronised low.
  - One-cycle press pulse is generated in the cycle the counter reaches DEB_CYC.
  - Holding the button produces no further pulses; a new pulse needs a release first.
  - Glitches shorter than DEB_CYC cycles produce no pulse.
  - Latency: if raw input is high from edge k, the pulse is high in cycle k+1+DEB_CYC (2 sync flops plus count).
- Breakpoint match (combinational): bp_match = bp_en & (if_pc==bp_pc) & ~skip.
- step (combinational): step = (state==RUN | state==BURST) & ~bp_match & ~halt_pulse.
  - Result: the pipeline never advances past a breakpointed fetch PC. The bp instruction stays in IF.
- FSM transitions, priority in each state is halt_pulse > bp_match > run/step pulses:
  - HALT:
    - run_pulse -> RUN.
    - Otherwise step_pulse -> BURST, with remaining=max(burst_len,1) latched at that edge.
  - RUN:
    - halt_pulse -> HALT.
    - bp_match -> BPHIT.
    - run_pulse and step_pulse are ignored.
  - BURST:
    - halt_pulse -> HALT.
    - bp_match -> BPHIT.
    - Otherwise remaining decrements on each step cycle. When remaining==1 during a step cycle -> HALT.
    - Exactly max(burst_len,1) step cycles occur unless interrupted. Pulses other than halt are ignored.
  - BPHIT:
    - step=0.
    - run_pulse -> RUN, and sets skip.
    - Otherwise step_pulse -> BURST (latches remaining) and sets skip.
    - halt_pulse -> HALT, skip unchanged.
- skip flag:
  - Set when leaving BPHIT for RUN or BURST.
  - Cleared on the first edge where if_pc != bp_pc.
  - Purpose: the pipeline can advance off the breakpointed PC, and the same bp re-triggers on a later revisit (loops).
- Changing bp_pc or bp_en while in BPHIT does not leave BPHIT.
- adv_cnt increments at each edge where step=1; 0xFFFFFFFF wraps to 0.
- bp_hit = (state==BPHIT). Outputs are registered except step.

Test Plan:
1. Reset, then hold btn_run high 10 cycles (DEB_CYC=4):
   - Single run pulse in cycle 5 after first high edge; state=RUN next cycle; step=1 continuously.
   - A 3-cycle btn_run glitch in HALT gives no pulse; state stays HALT.
2. burst_len=3, step press from HALT:
   - Exactly 3 consecutive step=1 cycles, then state=HALT; adv_cnt=3.
   - Repeat with burst_len=0: exactly 1 step cycle.
3. RUN with bp_en=1, bp_pc=0x10, if_pc counting 0,4,8,…:
   - step=0 in the cycle if_pc=0x10; state=BPHIT, bp_hit=1; if_pc holds 0x10.
4. From test 3, press step with burst_len=1:
   - One step cycle; if_pc becomes 0x14; skip clears; state=HALT.
   - Run again with if_pc looping back to 0x10: stops again at BPHIT.
5. Mid-burst (burst_len=200) assert halt press:
   - step=0 in the halt-pulse cycle; state=HALT next edge.
   - Separately, assert rst mid-burst: state=HALT, adv_cnt=0, step=0 next cycle.
6. Preload adv_cnt near wrap by running 2^32-2 cycles (or force), then run 3 cycles:
   - adv_cnt sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
